// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Provides the FSM state type, digit width and a power-of-ten helper.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DIGIT_W = 4;

  // Elaboration-time 10**n, wide enough for any practical digit count.
  function automatic logic [127:0] pow10(input int n);
    logic [127:0] r;
    r = 128'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 128'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit correction step for double dabble.
// A digit of 5 or more gets +3 so the following shift carries correctly.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  // Add 3 to digits that would reach 10 or more after doubling.
  always_comb begin
    d_o = d_i;
    if (d_i >= DIGIT_W'(5)) begin
      d_o = d_i + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
// Result digits, leading-zero blank mask and overflow are held for display.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W_BIN  = 27,
  parameter int DIGITS = 8
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic [W_BIN-1:0]           bin_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DIGIT_W*DIGITS-1:0]  bcd_o,
  output logic [DIGITS-1:0]          blank_o,
  output logic                       overflow_o,
  output logic                       valid_o
);

  localparam int SW    = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(W_BIN + 1);
  localparam int LIM_W = ((W_BIN > SW) ? W_BIN : SW) + 1;

  // Largest value that fits in DIGITS decimal digits.
  localparam logic [LIM_W-1:0] MAX_VAL =
    LIM_W'(pow10(DIGITS) - 128'd1);

  localparam logic [DIGITS-1:0] BLANK_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W_BIN-1:0]   bin_q, bin_d;
  logic [SW-1:0]      scr_q, scr_d;
  logic               ovf_q, ovf_d;
  logic [SW-1:0]      bcd_q, bcd_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               ovfo_q, ovfo_d;
  logic               valid_q, valid_d;

  logic [SW-1:0]      adj;
  logic [SW-1:0]      scr_sh;
  logic [DIGITS-1:0]  blank_nx;
  logic               run;
  logic               acc_ovf;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scr_q[g*DIGIT_W +: DIGIT_W]),
      .d_o (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign scr_sh  = {adj[SW-2:0], bin_q[W_BIN-1]};
  assign acc_ovf = LIM_W'(bin_i) > MAX_VAL;

  assign ready_o    = (state_q == IDLE) && !arst_i;
  assign bcd_o      = bcd_q;
  assign blank_o    = blank_q;
  assign overflow_o = ovfo_q;
  assign valid_o    = valid_q;

  // Leading-zero mask of the final shifted digits; digit 0 never blanks.
  always_comb begin
    blank_nx = '0;
    run      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run         = run & (scr_sh[i*DIGIT_W +: DIGIT_W] == '0);
      blank_nx[i] = run;
    end
  end

  // Next-state, datapath and result-load logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    ovfo_d  = ovfo_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          bin_d   = bin_i;
          scr_d   = '0;
          cnt_d   = CNT_W'(W_BIN);
          ovf_d   = acc_ovf;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = {bin_q[W_BIN-2:0], 1'b0};
        scr_d = scr_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = ovf_q ? {DIGITS{4'h9}} : scr_sh;
          blank_d = ovf_q ? '0 : blank_nx;
          ovfo_d  = ovf_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately on reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      ovfo_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovfo_q  <= ovfo_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_bin2bcd_seq;

  localparam int LAT = 27;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [26:0] bin_i = '0;
  logic        ready_o;
  logic [31:0] bcd_o;
  logic [7:0]  blank_o;
  logic        overflow_o;
  logic        valid_o;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  blank;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n5;
  logic bad;

  bin2bcd_seq dut (
    .clk_i      (clk),
    .arst_i     (arst_i),
    .bin_i      (bin_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .bcd_o      (bcd_o),
    .blank_o    (blank_o),
    .overflow_o (overflow_o),
    .valid_o    (valid_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got bcd_o=%h expected none",
                 bcd_o);
      end else begin
        me = q.pop_front();
        chk("bcd", 64'(bcd_o), 64'(me.bcd));
        chk("blank", 64'(blank_o), 64'(me.blank));
        chk("ovf", 64'(overflow_o), 64'(me.ovf));
        chk("latency", 64'(cyc - me.acc), 64'(LAT));
      end
    end
  end

  // Called at a negedge; waits for ready, then accepts on next posedge.
  task automatic issue(input logic [26:0] b, input logic [31:0] eb,
                       input logic [7:0] ebl, input logic eo,
                       input bit push, input bit keep);
    int   n;
    exp_t e;
    n = 0;
    bin_i = b;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ready_o=%b expected 1", ready_o);
    end else if (push) begin
      e.bcd = eb;
      e.blank = ebl;
      e.ovf = eo;
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    if (!keep) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  task automatic send(input logic [26:0] b, input logic [31:0] eb,
                      input logic [7:0] ebl, input logic eo);
    @(negedge clk);
    issue(b, eb, ebl, eo, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bcd", 64'(bcd_o), 64'h0);
    chk("rst_blank", 64'(blank_o), 64'hFE);
    chk("rst_ovf", 64'(overflow_o), 64'h0);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_ready", 64'(ready_o), 64'h0);
    arst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ready_o), 64'h1);

    send(27'd12_345_678, 32'h12345678, 8'h00, 1'b0);
    drain();
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bcd_o !== 32'h12345678 || blank_o !== 8'h00 ||
          overflow_o !== 1'b0 || valid_o !== 1'b0)
        bad = 1'b1;
    end
    chk("hold_100", 64'(bad), 64'h0);

    send(27'd0, 32'h0, 8'hFE, 1'b0);
    send(27'd907, 32'h00000907, 8'hF8, 1'b0);
    drain();

    send(27'd99_999_999, 32'h99999999, 8'h00, 1'b0);
    send(27'd100_000_000, 32'h99999999, 8'h00, 1'b1);
    send(27'd134_217_727, 32'h99999999, 8'h00, 1'b1);
    drain();

    @(negedge clk);
    issue(27'd300, 32'h00000300, 8'hF8, 1'b0, 1'b1, 1'b1);
    n5 = 0;
    do begin
      @(negedge clk);
      if (ready_o !== 1'b1) bin_i = 27'($urandom);
      n5++;
    end while (ready_o !== 1'b1 && n5 < 60);
    chk("b2b_ready_in_valid_cycle", 64'(valid_o), 64'h1);
    issue(27'd42, 32'h00000042, 8'hFC, 1'b0, 1'b1, 1'b0);
    drain();

    @(negedge clk);
    issue(27'd555, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 arst_i = 1'b1;
    #1;
    chk("midrst_bcd", 64'(bcd_o), 64'h0);
    chk("midrst_blank", 64'(blank_o), 64'hFE);
    chk("midrst_ovf", 64'(overflow_o), 64'h0);
    chk("midrst_valid", 64'(valid_o), 64'h0);
    chk("midrst_ready", 64'(ready_o), 64'h0);
    repeat (3) @(negedge clk);
    arst_i = 1'b0;
    repeat (35) @(negedge clk);
    send(27'd555, 32'h00000555, 8'hF8, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
